// File: rtl/pixlink_pkg.sv
// Shared types and constants for the pixel capture link: transmit FSM states,
// pixel/nibble widths and the pad nibble that fills the top of each pixel word.
package pixlink_pkg;

  localparam int PIX_W = 16;
  localparam int NIB_W = 4;
  localparam logic [NIB_W-1:0] PIX_PAD = 4'h0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    PAR   = 3'd5,
    STOP  = 3'd6
  } pixsend_state_t;

  // Pixel word layout: pad in the top nibble, then R, G, B with B in the LSBs.
  function automatic logic [PIX_W-1:0] pack_pixel(input logic [NIB_W-1:0] r,
                                                  input logic [NIB_W-1:0] g,
                                                  input logic [NIB_W-1:0] b);
    return {PIX_PAD, r, g, b};
  endfunction

endpackage

// File: rtl/pixel_drain_tx_bit_timer.sv
// Serial bit timer: counts 0..CLKS_PER_BIT-1 while running and pulses tick on
// the last count, then wraps. Cleared when a new pixel is loaded.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic res_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pixel_drain_tx.sv
// Pops one R/G/B nibble triple from the capture queues and sends the packed
// 16-bit pixel LSB first as start/data/[parity]/stop. Parity: PIXSEND_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for En and all three queues non-empty
// POP   | rdreq to all three queues for one cycle
// LOAD  | queue data valid; capture pixel, clear timer and bit index
// START | start bit (SIO=0)
// DATA  | 16 data bits, LSB first
// PAR   | even parity bit (only with PIXSEND_PARITY_EN)
// STOP  | stop bit (SIO=1)
module pixel_drain_tx
  import pixlink_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             En,
  input  logic             Remp,
  input  logic             Gemp,
  input  logic             Bemp,
  input  logic [NIB_W-1:0] RedOt,
  input  logic [NIB_W-1:0] GreOt,
  input  logic [NIB_W-1:0] BluOt,
  output logic             Req,
  output logic             Greq,
  output logic             Blreq,
  output logic             SIO,
  output logic             Busy
);

  pixsend_state_t   state, state_nxt;
  logic [PIX_W-1:0] shreg;
  logic [3:0]       idx;
  logic             tick;
  logic             timer_run;
  logic             start_ok;

  assign timer_run = (state == START) || (state == DATA) ||
                     (state == PAR)   || (state == STOP);
  assign start_ok  = En && !Remp && !Gemp && !Bemp;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_bit_timer (
    .clk  (clk),
    .res_n(res_n),
    .clr  (state == LOAD),
    .run  (timer_run),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_ok) state_nxt = POP;
      POP:   state_nxt = LOAD;
      LOAD:  state_nxt = START;
      START: if (tick) state_nxt = DATA;
      DATA: begin
        if (tick && (idx == 4'd15)) begin
`ifdef PIXSEND_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef PIXSEND_PARITY_EN
      PAR:   if (tick) state_nxt = STOP;
`endif
      STOP:  if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The shift register is consumed as it goes out; bit 0 is always the live data bit.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      shreg <= '0;
      idx   <= '0;
    end else if (state == LOAD) begin
      shreg <= pack_pixel(RedOt, GreOt, BluOt);
      idx   <= '0;
    end else if ((state == DATA) && tick) begin
      shreg <= shreg >> 1;
      idx   <= idx + 4'd1;
    end
  end

`ifdef PIXSEND_PARITY_EN
  logic par_bit;

  // Parity is latched at load because the shift register no longer holds the word later.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      par_bit <= 1'b0;
    end else if (state == LOAD) begin
      par_bit <= ^pack_pixel(RedOt, GreOt, BluOt);
    end
  end
`endif

  always_comb begin
    SIO = 1'b1;
    case (state)
      START: SIO = 1'b0;
      DATA:  SIO = shreg[0];
`ifdef PIXSEND_PARITY_EN
      PAR:   SIO = par_bit;
`endif
      default: SIO = 1'b1;
    endcase
  end

  assign Req   = (state == POP);
  assign Greq  = (state == POP);
  assign Blreq = (state == POP);
  assign Busy  = (state != IDLE);

endmodule

// File: tb/tb_pixel_drain_tx.sv
// Bench for pixel_drain_tx: emulated capture queues plus a frame-level model
// that predicts pops and the serial line cycle by cycle.
module tb_pixel_drain_tx;

  localparam int CPB = 4;
`ifdef PIXSEND_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FBITS   = 18 + P;
  localparam int SPACING = FBITS * CPB + 3;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       En = 1'b0;
  logic       Remp = 1'b1, Gemp = 1'b1, Bemp = 1'b1;
  logic [3:0] RedOt = 4'h0, GreOt = 4'h0, BluOt = 4'h0;
  logic       Req, Greq, Blreq, SIO, Busy;

  pixel_drain_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .res_n(res_n),
    .En   (En),
    .Remp (Remp),
    .Gemp (Gemp),
    .Bemp (Bemp),
    .RedOt(RedOt),
    .GreOt(GreOt),
    .BluOt(BluOt),
    .Req  (Req),
    .Greq (Greq),
    .Blreq(Blreq),
    .SIO  (SIO),
    .Busy (Busy)
  );

  always #5 clk = ~clk;

  // queue emulation (driven by DUT rdreq) and model copies (driven by prediction)
  logic [3:0] fr[$], fg[$], fb[$];
  logic [3:0] mr[$], mg[$], mb[$];
  bit         fe_r = 0, fe_g = 0, fe_b = 0;

  int   checks = 0;
  int   errors = 0;
  int   cyc_n = 0;
  bit   last_idle = 1;
  bit   pop_pending = 0;
  bit   exp_line[$];
  int   pop_times[$];
  int   rcnt = 0, gcnt = 0, bcnt = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic upd_emp();
    Remp = (fr.size() == 0) || fe_r;
    Gemp = (fg.size() == 0) || fe_g;
    Bemp = (fb.size() == 0) || fe_b;
  endtask

  task automatic push_pix(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    fr.push_back(r); fg.push_back(g); fb.push_back(b);
    mr.push_back(r); mg.push_back(g); mb.push_back(b);
    upd_emp();
  endtask

  // One clock cycle: inputs as they stand now are what the next edge sees.
  task automatic step();
    bit         exp_req, had, exp_s;
    logic [3:0] r, g, b;
    logic [15:0] word;
    logic [19:0] fbits;
    pop_pending = last_idle && res_n && En && !Remp && !Gemp && !Bemp;
    @(negedge clk);
    cyc_n++;
    exp_req = pop_pending;
    had     = (exp_line.size() > 0);
    exp_s   = had ? exp_line.pop_front() : 1'b1;
    chk("req", Req, exp_req);
    chk("greq", Greq, exp_req);
    chk("blreq", Blreq, exp_req);
    chk("sio", SIO, exp_s);
    chk("busy", Busy, exp_req || had);
    if (Req) begin rcnt++; pop_times.push_back(cyc_n); end
    if (Greq) gcnt++;
    if (Blreq) bcnt++;
    if (Req && fr.size() > 0) RedOt = fr.pop_front();
    if (Greq && fg.size() > 0) GreOt = fg.pop_front();
    if (Blreq && fb.size() > 0) BluOt = fb.pop_front();
    if (exp_req && mr.size() > 0 && mg.size() > 0 && mb.size() > 0) begin
      r = mr.pop_front(); g = mg.pop_front(); b = mb.pop_front();
      word  = {4'h0, r, g, b};
      fbits = {3'b111, word, 1'b0};
      if (P == 1) fbits[17] = ^word;
      exp_line.push_back(1'b1);  // LOAD cycle
      for (int i = 0; i < FBITS; i++)
        for (int j = 0; j < CPB; j++)
          exp_line.push_back(fbits[i]);
    end
    last_idle = !exp_req && !had;
    upd_emp();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pop(input string tag, input int limit);
    bit found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      step();
      if (Req) found = 1;
    end
    chk(tag, found, 1'b1);
  endtask

  initial begin
    int base, n0;
    upd_emp();
    #12;
    chk("rst_sio", SIO, 1'b1);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_req", Req, 1'b0);
    @(negedge clk);
    res_n = 1'b1;
    last_idle = 1;

    // single pixel 05A3
    En = 1'b1;
    push_pix(4'h5, 4'hA, 4'h3);
    base = rcnt;
    run(SPACING + 10);
    chk_int("single_pops", rcnt - base, 1);

    // green empty blocks start
    fe_g = 1;
    push_pix(4'h9, 4'h1, 4'hE);
    base = rcnt;
    run(50);
    chk_int("gemp_no_pop", rcnt - base, 0);
    fe_g = 0;
    upd_emp();
    step();
    chk("gemp_release_pop", Req, 1'b1);
    run(SPACING + 5);

    // back-to-back
    base = rcnt;
    n0 = pop_times.size();
    for (int k = 0; k < 3; k++)
      push_pix(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
    run(3 * SPACING + 20);
    chk_int("b2b_red_pops", rcnt - base, 3);
    chk_int("b2b_grn_pops", gcnt - base, 3);
    chk_int("b2b_blu_pops", bcnt - base, 3);
    if (pop_times.size() >= n0 + 3) begin
      chk_int("b2b_space1", pop_times[n0+1] - pop_times[n0], SPACING);
      chk_int("b2b_space2", pop_times[n0+2] - pop_times[n0+1], SPACING);
    end

    // En drop mid-frame
    push_pix(4'h7, 4'h3, 4'hC);
    push_pix(4'h2, 4'hD, 4'h6);
    base = rcnt;
    wait_pop("endrop_first_pop", 10);
    run(30);
    En = 1'b0;
    run(200);
    chk_int("endrop_one_pop", rcnt - base, 1);
    En = 1'b1;
    step();
    chk("endrop_resume_pop", Req, 1'b1);
    run(SPACING + 5);

    // reset during DATA bit 7
    push_pix(4'hF, 4'h0, 4'h8);
    push_pix(4'h4, 4'hB, 4'h1);
    wait_pop("rst_first_pop", 10);
    run(34);
    #1 res_n = 1'b0;
    #1;
    chk("rstmid_sio", SIO, 1'b1);
    chk("rstmid_busy", Busy, 1'b0);
    exp_line.delete();
    last_idle = 1;
    run(3);
    res_n = 1'b1;
    step();
    chk("rstmid_fresh_pop", Req, 1'b1);
    run(SPACING + 5);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      int np = $urandom_range(2);
      for (int k = 0; k < np; k++)
        if (fr.size() < 4)
          push_pix(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
      En   = ($urandom_range(3) != 0);
      fe_r = ($urandom_range(7) == 0);
      fe_g = ($urandom_range(7) == 0);
      fe_b = ($urandom_range(7) == 0);
      upd_emp();
      run($urandom_range(150, 1));
    end
    fe_r = 0; fe_g = 0; fe_b = 0;
    En = 1'b1;
    upd_emp();
    run((fr.size() + 1) * SPACING + 20);
    chk_int("drain_fifo", fr.size(), 0);
    chk_int("drain_model", mr.size(), 0);
    chk_int("drain_line", exp_line.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
